// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: PC register, 12-bit memory address, one-deep fetch register,
// branch/jump/jump-register redirects with stall and halt-on-fault. Optional counters: FETCH_PERF_CNT_EN.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [15:0] BranchOffset,
    input  logic        Jump,
    input  logic [25:0] JumpIndex,
    input  logic        JumpReg,
    input  logic [31:0] JumpRegTarget,
    output logic [11:0] ReadAddress,
    input  logic [31:0] Instruction,
    output logic [31:0] FetchInstr,
    output logic [31:0] FetchPC,
    output logic        FetchValid,
    output logic        Halted,
    output logic [1:0]  FaultCode
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] FetchCount,
    output logic [31:0] FlushCount
`endif
);

    if ((RESET_PC[1:0] != 2'b00) || (RESET_PC[31:12] != 20'h0)) begin : g_bad_reset_pc
        $error("fetch_pc_unit: RESET_PC must be word-aligned and below 0x1000");
    end

    // state | meaning
    // RUN   | fetching; PC advances or redirects unless stalled
    // HALT  | illegal fetch target seen; frozen until reset
    typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_instr;
    logic [31:0] r_fetch_pc;
    logic        r_fetch_valid;
    logic [1:0]  r_fault;

    logic [31:0] w_base;
    logic [31:0] w_br_target;
    logic [31:0] w_j_target;
    logic [31:0] w_target;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_advance;
    logic [1:0]  w_fault_code;

    // Redirects are relative to the instruction sitting in the fetch register.
    assign w_base      = r_fetch_pc + 32'd4;
    assign w_br_target = w_base + {{14{BranchOffset[15]}}, BranchOffset, 2'b00};
    assign w_j_target  = {w_base[31:28], JumpIndex, 2'b00};
    assign w_redirect  = JumpReg | Jump | Branch;
    assign w_advance   = (r_state == RUN) && !Stall;

    always_comb begin
        w_target = w_br_target;
        if (JumpReg) begin
            w_target = JumpRegTarget;
        end else if (Jump) begin
            w_target = w_j_target;
        end
    end

    assign w_next_pc = w_redirect ? w_target : (r_pc + 32'd4);

    always_comb begin
        w_fault_code = 2'b00;
        if (w_next_pc[1:0] != 2'b00) begin
            w_fault_code = 2'b01;
        end else if (w_next_pc[31:12] != 20'h0) begin
            w_fault_code = 2'b10;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_advance && (w_fault_code != 2'b00)) begin
            w_state_next = HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_fetch_instr <= 32'h0;
            r_fetch_pc    <= 32'h0;
            r_fetch_valid <= 1'b0;
            r_fault       <= 2'b00;
        end else if (r_state == HALT) begin
            r_fetch_valid <= 1'b0;
        end else if (!Stall) begin
            r_fetch_pc    <= r_pc;
            r_fetch_instr <= w_redirect ? 32'h0 : Instruction;
            r_fetch_valid <= !w_redirect;
            // A faulting target never reaches the PC, so ReadAddress stays on the last legal word.
            if (w_fault_code != 2'b00) begin
                r_fault <= w_fault_code;
            end else begin
                r_pc <= w_next_pc;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt <= 32'h0;
            r_flush_cnt <= 32'h0;
        end else if (w_advance) begin
            if (!w_redirect && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_redirect && (r_flush_cnt != 32'hFFFF_FFFF)) begin
                r_flush_cnt <= r_flush_cnt + 32'd1;
            end
        end
    end

    assign FetchCount = r_fetch_cnt;
    assign FlushCount = r_flush_cnt;
`endif

    assign ReadAddress = r_pc[11:0];
    assign FetchInstr  = r_fetch_instr;
    assign FetchPC     = r_fetch_pc;
    assign FetchValid  = r_fetch_valid;
    assign Halted      = (r_state == HALT);
    assign FaultCode   = r_fault;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized redirects/stalls
// against a behavioural model of the fetch rules.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Branch;
    logic [15:0] BranchOffset;
    logic        Jump;
    logic [25:0] JumpIndex;
    logic        JumpReg;
    logic [31:0] JumpRegTarget;
    logic [11:0] ReadAddress;
    logic [31:0] Instruction;
    logic [31:0] FetchInstr;
    logic [31:0] FetchPC;
    logic        FetchValid;
    logic        Halted;
    logic [1:0]  FaultCode;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc, m_fi, m_fpc;
    logic        m_fv, m_halt;
    logic [1:0]  m_fault;
    logic [31:0] m_fetch_cnt, m_flush_cnt;

    fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .Stall(Stall),
        .Branch(Branch), .BranchOffset(BranchOffset),
        .Jump(Jump), .JumpIndex(JumpIndex),
        .JumpReg(JumpReg), .JumpRegTarget(JumpRegTarget),
        .ReadAddress(ReadAddress), .Instruction(Instruction),
        .FetchInstr(FetchInstr), .FetchPC(FetchPC), .FetchValid(FetchValid),
        .Halted(Halted), .FaultCode(FaultCode)
`ifdef FETCH_PERF_CNT_EN
        , .FetchCount(FetchCount), .FlushCount(FlushCount)
`endif
    );

    assign Instruction = mem[ReadAddress[11:2]];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle();
        Stall = 0; Branch = 0; BranchOffset = 0; Jump = 0; JumpIndex = 0;
        JumpReg = 0; JumpRegTarget = 0;
    endtask

    // Apply the fetch rules to the model using the inputs present before the edge.
    task automatic step();
        logic [31:0] n_pc, n_fi, n_fpc, b, tgt, np, fc, fl;
        logic        n_fv, n_halt, redir;
        logic [1:0]  n_fault;
        n_pc = m_pc; n_fi = m_fi; n_fpc = m_fpc; n_fv = m_fv; n_halt = m_halt; n_fault = m_fault;
        fc = m_fetch_cnt; fl = m_flush_cnt;
        if (reset) begin
            n_pc = RESET_PC; n_fi = 0; n_fpc = 0; n_fv = 0; n_halt = 0; n_fault = 0; fc = 0; fl = 0;
        end else if (m_halt) begin
            n_fv = 0;
        end else if (!Stall) begin
            b     = m_fpc + 4;
            redir = JumpReg || Jump || Branch;
            if (JumpReg)     tgt = JumpRegTarget;
            else if (Jump)   tgt = {b[31:28], JumpIndex, 2'b00};
            else             tgt = b + 32'($signed(BranchOffset)) * 4;
            np    = redir ? tgt : m_pc + 4;
            n_fpc = m_pc;
            n_fv  = !redir;
            n_fi  = redir ? 32'h0 : mem[m_pc[11:2]];
            if (redir) begin
                if (fl != 32'hFFFF_FFFF) fl = fl + 1;
            end else if (fc != 32'hFFFF_FFFF) fc = fc + 1;
            if (np % 4 != 0) begin
                n_halt = 1; n_fault = 2'b01;
            end else if (np >= 32'h1000) begin
                n_halt = 1; n_fault = 2'b10;
            end else begin
                n_pc = np;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_fi = n_fi; m_fpc = n_fpc; m_fv = n_fv; m_halt = n_halt; m_fault = n_fault;
        m_fetch_cnt = fc; m_flush_cnt = fl;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h1111_1111; mem[1] = 32'h2222_2222; mem[2] = 32'h3333_3333;
        idle();
        reset = 1;
        step();
        step();
        n_tests++;
        if (ReadAddress !== RESET_PC[11:0]) begin n_fail++; $display("FAIL reset_addr got=%h exp=%h", ReadAddress, RESET_PC[11:0]); end
        n_tests++;
        if ({FetchValid, Halted, FaultCode, FetchPC, FetchInstr} !== 68'h0) begin
            n_fail++; $display("FAIL reset_regs got v=%b h=%b f=%b pc=%h i=%h exp all zero", FetchValid, Halted, FaultCode, FetchPC, FetchInstr);
        end
    endtask

    task automatic test_sequential();
        reset = 0;
        step();
        n_tests++;
        if (FetchInstr !== 32'h1111_1111 || FetchPC !== 32'h0 || FetchValid !== 1'b1 || ReadAddress !== 12'h004) begin
            n_fail++; $display("FAIL seq_first got i=%h pc=%h v=%b ra=%h exp i=11111111 pc=0 v=1 ra=004", FetchInstr, FetchPC, FetchValid, ReadAddress);
        end
        step();
        n_tests++;
        if (FetchInstr !== 32'h2222_2222 || FetchPC !== 32'h4 || FetchValid !== 1'b1 || ReadAddress !== 12'h008) begin
            n_fail++; $display("FAIL seq_second got i=%h pc=%h v=%b ra=%h exp i=22222222 pc=4 v=1 ra=008", FetchInstr, FetchPC, FetchValid, ReadAddress);
        end
    endtask

    task automatic test_stall();
        Stall = 1; Branch = 1; BranchOffset = 16'h0010;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (FetchInstr !== 32'h2222_2222 || FetchPC !== 32'h4 || FetchValid !== 1'b1 || ReadAddress !== 12'h008) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got i=%h pc=%h v=%b ra=%h exp i=22222222 pc=4 v=1 ra=008", c, FetchInstr, FetchPC, FetchValid, ReadAddress);
            end
        end
        idle();
    endtask

    task automatic redirect_check(input string name, input logic [31:0] exp_tgt);
        int budget;
        budget = 0;
        while (FetchPC !== 32'h10 && budget < 20) begin step(); budget++; end
        n_tests++;
        if (FetchPC !== 32'h10) begin n_fail++; $display("FAIL %s_reach got=%h exp=00000010", name, FetchPC); end
        step();
        idle();
        n_tests++;
        if (ReadAddress !== exp_tgt[11:0] || FetchValid !== 1'b0 || FetchInstr !== 32'h0) begin
            n_fail++; $display("FAIL %s_bubble got ra=%h v=%b i=%h exp ra=%h v=0 i=0", name, ReadAddress, FetchValid, FetchInstr, exp_tgt[11:0]);
        end
        step();
        n_tests++;
        if (FetchPC !== exp_tgt || FetchValid !== 1'b1 || FetchInstr !== mem[exp_tgt[11:2]]) begin
            n_fail++; $display("FAIL %s_target got pc=%h v=%b i=%h exp pc=%h v=1", name, FetchPC, FetchValid, FetchInstr, exp_tgt);
        end
    endtask

    task automatic test_redirects();
        // Branch issued in the cycle where FetchPC is 0x10: set inputs after reaching it.
        int budget;
        budget = 0;
        while (FetchPC !== 32'h10 && budget < 20) begin step(); budget++; end
        Branch = 1; BranchOffset = 16'hFFFC;
        redirect_check("branch", 32'h004);
        while (FetchPC !== 32'h10 && budget < 40) begin step(); budget++; end
        JumpReg = 1; Jump = 1; JumpIndex = 26'h3F; JumpRegTarget = 32'h100;
        redirect_check("jr_prio", 32'h100);
    endtask

    task automatic test_fault_misaligned();
        logic [11:0] ra0;
        JumpReg = 1; JumpRegTarget = 32'h102;
        ra0 = ReadAddress;
        step();
        idle();
        n_tests++;
        if (Halted !== 1'b1 || FaultCode !== 2'b01 || ReadAddress !== ra0) begin
            n_fail++; $display("FAIL misalign_halt got h=%b f=%b ra=%h exp h=1 f=01 ra=%h", Halted, FaultCode, ReadAddress, ra0);
        end
        Branch = 1; Jump = 1; JumpIndex = 26'h10;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (FetchValid !== 1'b0 || Halted !== 1'b1 || ReadAddress !== ra0 || FaultCode !== 2'b01) begin
                n_fail++; $display("FAIL halt_hold cyc=%0d got v=%b h=%b ra=%h f=%b exp v=0 h=1 ra=%h f=01", c, FetchValid, Halted, ReadAddress, FaultCode, ra0);
            end
        end
        idle();
        reset = 1;
        step();
        reset = 0;
        n_tests++;
        if (ReadAddress !== RESET_PC[11:0] || Halted !== 1'b0 || FaultCode !== 2'b00 || FetchValid !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset got ra=%h h=%b f=%b v=%b exp ra=%h h=0 f=00 v=0", ReadAddress, Halted, FaultCode, FetchValid, RESET_PC[11:0]);
        end
    endtask

    task automatic test_range();
        int budget;
        mem[1023] = 32'hDEAD_BEEF;
        step();
        JumpReg = 1; JumpRegTarget = 32'hFF0;
        step();
        idle();
        budget = 0;
        while (Halted !== 1'b1 && budget < 12) begin step(); budget++; end
        n_tests++;
        if (Halted !== 1'b1 || FaultCode !== 2'b10 || FetchPC !== 32'hFFC || FetchInstr !== 32'hDEAD_BEEF || FetchValid !== 1'b1 || ReadAddress !== 12'hFFC) begin
            n_fail++; $display("FAIL range_fault got h=%b f=%b pc=%h i=%h v=%b ra=%h exp h=1 f=10 pc=ffc i=deadbeef v=1 ra=ffc", Halted, FaultCode, FetchPC, FetchInstr, FetchValid, ReadAddress);
        end
        step();
        n_tests++;
        if (FetchValid !== 1'b0 || FetchInstr !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL range_after got v=%b i=%h exp v=0 i=deadbeef", FetchValid, FetchInstr);
        end
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        for (int c = 0; c < 600; c++) begin
            idle();
            reset = m_halt && ($urandom_range(0, 2) == 0);
            Stall = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0: begin Branch = 1; BranchOffset = 16'($urandom_range(0, 63)) - 16'd32; end
                1: begin Jump = 1; JumpIndex = 26'($urandom_range(0, 1023)); end
                2: begin JumpReg = 1; JumpRegTarget = 32'($urandom_range(0, 32'h1003)); end
                3: begin JumpReg = 1; Jump = 1; Branch = 1; JumpRegTarget = 32'($urandom_range(0, 1023)) << 2; end
                4: begin Jump = 1; Branch = 1; JumpIndex = 26'($urandom_range(0, 1023)); BranchOffset = 16'($urandom); end
                default: ;
            endcase
            step();
            n_tests++;
            if ({ReadAddress, FetchInstr, FetchPC, FetchValid, Halted, FaultCode} !==
                {m_pc[11:0], m_fi, m_fpc, m_fv, m_halt, m_fault}) begin
                n_fail++;
                if (errs < 10) $display("FAIL random cyc=%0d got ra=%h i=%h pc=%h v=%b h=%b f=%b exp ra=%h i=%h pc=%h v=%b h=%b f=%b",
                    c, ReadAddress, FetchInstr, FetchPC, FetchValid, Halted, FaultCode,
                    m_pc[11:0], m_fi, m_fpc, m_fv, m_halt, m_fault);
                errs++;
            end
`ifdef FETCH_PERF_CNT_EN
            n_tests++;
            if (FetchCount !== m_fetch_cnt || FlushCount !== m_flush_cnt) begin
                n_fail++; $display("FAIL random_cnt cyc=%0d got fc=%0d fl=%0d exp fc=%0d fl=%0d", c, FetchCount, FlushCount, m_fetch_cnt, m_flush_cnt);
            end
`endif
        end
        idle();
        reset = 1;
        step();
        reset = 0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        reset = 1;
        step();
        reset = 0;
        for (int c = 0; c < 5; c++) step();
        Jump = 1; JumpIndex = 26'h40;
        step();
        idle();
        n_tests++;
        if (FetchCount !== 32'd5 || FlushCount !== 32'd1) begin
            n_fail++; $display("FAIL perf_counts got fc=%0d fl=%0d exp fc=5 fl=1", FetchCount, FlushCount);
        end
        reset = 1;
        step();
        reset = 0;
        n_tests++;
        if (FetchCount !== 32'd0 || FlushCount !== 32'd0) begin
            n_fail++; $display("FAIL perf_reset got fc=%0d fl=%0d exp 0 0", FetchCount, FlushCount);
        end
    endtask
`endif

    initial begin
        m_pc = RESET_PC; m_fi = 0; m_fpc = 0; m_fv = 0; m_halt = 0; m_fault = 0;
        m_fetch_cnt = 0; m_flush_cnt = 0;
        reset = 1;
        idle();
        test_reset();
        test_sequential();
        test_stall();
        test_redirects();
        test_fault_misaligned();
        test_range();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
